// File: rtl/intirvx_axi_arbiter_pkg.sv
// Shared types and constants for the intirvx two-master to one-master AXI5 arbiter.
package intirvx_axi_arbiter_pkg;

  localparam int unsigned MAX_RD_OUT_DEF = 4;
  localparam int unsigned ID_W           = 4;
  localparam int unsigned ADDR_W         = 32;
  localparam int unsigned DATA_W         = 32;

  typedef enum logic {SRC_I = 1'b0, SRC_D = 1'b1} src_e;

  typedef enum logic {R_IDLE, R_OWN} rd_state_e;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_e;

endpackage

// File: rtl/axi5.sv
// AXI5 channel bundle used by the arbiter ports (address, data and response channels).
interface axi5;
  import intirvx_axi_arbiter_pkg::*;

  logic [ID_W-1:0]     awid;
  logic [ADDR_W-1:0]   awaddr;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;
  logic [ID_W-1:0]     bid;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ID_W-1:0]     arid;
  logic [ADDR_W-1:0]   araddr;
  logic [7:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic                arvalid;
  logic                arready;
  logic [ID_W-1:0]     rid;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid, input awready,
    output wdata, wstrb, wlast, wvalid, input wready,
    input bid, bresp, bvalid, output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid, input arready,
    input rid, rdata, rresp, rlast, rvalid, output rready
  );

  modport slave (
    input awid, awaddr, awlen, awsize, awburst, awvalid, output awready,
    input wdata, wstrb, wlast, wvalid, output wready,
    output bid, bresp, bvalid, input bready,
    input arid, araddr, arlen, arsize, arburst, arvalid, output arready,
    output rid, rdata, rresp, rlast, rvalid, input rready
  );

endinterface

// File: rtl/intirvx_axi_arb_grant.sv
// Two-way requester to one-hot grant (bit 1 = data side). Fixed d>i priority by default;
// round-robin pointer when INTIRVX_AXI_ARB_RR_EN is defined.
module intirvx_axi_arb_grant
  import intirvx_axi_arbiter_pkg::*;
(
`ifdef INTIRVX_AXI_ARB_RR_EN
  input  logic       clk,
  input  logic       rst_n,
  input  logic       take,
`endif
  input  logic [1:0] req,
  output logic [1:0] gnt
);

`ifdef INTIRVX_AXI_ARB_RR_EN
  src_e ptr_q;

  // Pointer moves to the source that lost (or did not take) the grant just issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= SRC_I;
    end else if (take && (req != 2'b00)) begin
      ptr_q <= (gnt == 2'b10) ? SRC_I : SRC_D;
    end
  end

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = (ptr_q == SRC_D) ? 2'b10 : 2'b01;
    end
  end
`else
  always_comb begin
    gnt = req[1] ? 2'b10 : {1'b0, req[0]};
  end
`endif

endmodule

// File: rtl/intirvx_axi_arbiter.sv
// Merges intirvx i_axi/d_axi into one AXI5 master; reads and writes arbitrated independently.
// Define INTIRVX_AXI_ARB_RR_EN for round-robin grant instead of fixed d>i priority.
module intirvx_axi_arbiter
  import intirvx_axi_arbiter_pkg::*;
#(
  parameter int unsigned MAX_RD_OUT = MAX_RD_OUT_DEF,
  parameter int unsigned CNT_W      = 4
) (
  input logic clk,
  input logic rst_n,
  axi5.slave  i_axi,
  axi5.slave  d_axi,
  axi5.master m_axi
);

  // ---------------- Read path ----------------
  rd_state_e        rd_state_q, rd_state_d;
  src_e             rd_owner_q, rd_owner_d;
  logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
  logic [1:0]       ar_req, ar_gnt;
  logic             rd_own, rd_sel_d, rd_room, own_arvalid, ar_hs, rl_hs;

  assign ar_req = {d_axi.arvalid, i_axi.arvalid};

  intirvx_axi_arb_grant u_rd_grant (
`ifdef INTIRVX_AXI_ARB_RR_EN
    .clk   (clk),
    .rst_n (rst_n),
    .take  (rd_state_q == R_IDLE),
`endif
    .req   (ar_req),
    .gnt   (ar_gnt)
  );

  assign rd_own      = (rd_state_q == R_OWN);
  assign rd_sel_d    = (rd_owner_q == SRC_D);
  assign rd_room     = (rd_cnt_q < CNT_W'(MAX_RD_OUT));
  assign own_arvalid = rd_sel_d ? d_axi.arvalid : i_axi.arvalid;

  assign m_axi.arvalid = rd_own & rd_room & own_arvalid;
  assign m_axi.arid    = rd_sel_d ? d_axi.arid    : i_axi.arid;
  assign m_axi.araddr  = rd_sel_d ? d_axi.araddr  : i_axi.araddr;
  assign m_axi.arlen   = rd_sel_d ? d_axi.arlen   : i_axi.arlen;
  assign m_axi.arsize  = rd_sel_d ? d_axi.arsize  : i_axi.arsize;
  assign m_axi.arburst = rd_sel_d ? d_axi.arburst : i_axi.arburst;
  assign m_axi.rready  = rd_own & (rd_sel_d ? d_axi.rready : i_axi.rready);

  assign i_axi.arready = rd_own & ~rd_sel_d & rd_room & m_axi.arready;
  assign d_axi.arready = rd_own &  rd_sel_d & rd_room & m_axi.arready;
  assign i_axi.rvalid  = rd_own & ~rd_sel_d & m_axi.rvalid;
  assign d_axi.rvalid  = rd_own &  rd_sel_d & m_axi.rvalid;
  assign i_axi.rid     = m_axi.rid;
  assign d_axi.rid     = m_axi.rid;
  assign i_axi.rdata   = m_axi.rdata;
  assign d_axi.rdata   = m_axi.rdata;
  assign i_axi.rresp   = m_axi.rresp;
  assign d_axi.rresp   = m_axi.rresp;
  assign i_axi.rlast   = m_axi.rlast;
  assign d_axi.rlast   = m_axi.rlast;

  assign ar_hs = m_axi.arvalid & m_axi.arready;
  assign rl_hs = m_axi.rvalid & m_axi.rready & m_axi.rlast;

  always_comb begin
    rd_state_d = rd_state_q;
    rd_owner_d = rd_owner_q;
    rd_cnt_d   = rd_cnt_q;
    unique case (rd_state_q)
      R_IDLE: begin
        if (ar_req != 2'b00) begin
          rd_state_d = R_OWN;
          rd_owner_d = (ar_gnt == 2'b10) ? SRC_D : SRC_I;
        end
      end
      R_OWN: begin
        if (ar_hs && !rl_hs) begin
          rd_cnt_d = rd_cnt_q + 1'b1;
        end else if (!ar_hs && rl_hs) begin
          rd_cnt_d = rd_cnt_q - 1'b1;
        end
        // A pending owner AR keeps the grant even as the count drains to zero.
        if ((rd_cnt_d == '0) && !own_arvalid) begin
          rd_state_d = R_IDLE;
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state_q <= R_IDLE;
      rd_owner_q <= SRC_I;
      rd_cnt_q   <= '0;
    end else begin
      rd_state_q <= rd_state_d;
      rd_owner_q <= rd_owner_d;
      rd_cnt_q   <= rd_cnt_d;
    end
  end

  // ---------------- Write path ----------------
  wr_state_e wr_state_q, wr_state_d;
  src_e      wr_owner_q, wr_owner_d;
  logic      aw_done_q, aw_done_d;
  logic [1:0] aw_req, aw_gnt;
  logic      wr_sel_d, wr_data, wr_resp, own_wlast, w_open, aw_hs, w_hs, b_hs;

  assign aw_req = {d_axi.awvalid, i_axi.awvalid};

  intirvx_axi_arb_grant u_wr_grant (
`ifdef INTIRVX_AXI_ARB_RR_EN
    .clk   (clk),
    .rst_n (rst_n),
    .take  (wr_state_q == W_IDLE),
`endif
    .req   (aw_req),
    .gnt   (aw_gnt)
  );

  assign wr_sel_d  = (wr_owner_q == SRC_D);
  assign wr_data   = (wr_state_q == W_DATA);
  assign wr_resp   = (wr_state_q == W_RESP);
  assign own_wlast = wr_sel_d ? d_axi.wlast : i_axi.wlast;
  // Early W beats may flow, but the last beat waits for the AW handshake.
  assign w_open    = aw_done_q | ~own_wlast;

  assign m_axi.awvalid = wr_data & ~aw_done_q & (wr_sel_d ? d_axi.awvalid : i_axi.awvalid);
  assign m_axi.awid    = wr_sel_d ? d_axi.awid    : i_axi.awid;
  assign m_axi.awaddr  = wr_sel_d ? d_axi.awaddr  : i_axi.awaddr;
  assign m_axi.awlen   = wr_sel_d ? d_axi.awlen   : i_axi.awlen;
  assign m_axi.awsize  = wr_sel_d ? d_axi.awsize  : i_axi.awsize;
  assign m_axi.awburst = wr_sel_d ? d_axi.awburst : i_axi.awburst;
  assign m_axi.wvalid  = wr_data & w_open & (wr_sel_d ? d_axi.wvalid : i_axi.wvalid);
  assign m_axi.wdata   = wr_sel_d ? d_axi.wdata : i_axi.wdata;
  assign m_axi.wstrb   = wr_sel_d ? d_axi.wstrb : i_axi.wstrb;
  assign m_axi.wlast   = own_wlast;
  assign m_axi.bready  = wr_resp & (wr_sel_d ? d_axi.bready : i_axi.bready);

  assign i_axi.awready = wr_data & ~wr_sel_d & ~aw_done_q & m_axi.awready;
  assign d_axi.awready = wr_data &  wr_sel_d & ~aw_done_q & m_axi.awready;
  assign i_axi.wready  = wr_data & ~wr_sel_d & w_open & m_axi.wready;
  assign d_axi.wready  = wr_data &  wr_sel_d & w_open & m_axi.wready;
  assign i_axi.bvalid  = wr_resp & ~wr_sel_d & m_axi.bvalid;
  assign d_axi.bvalid  = wr_resp &  wr_sel_d & m_axi.bvalid;
  assign i_axi.bid     = m_axi.bid;
  assign d_axi.bid     = m_axi.bid;
  assign i_axi.bresp   = m_axi.bresp;
  assign d_axi.bresp   = m_axi.bresp;

  assign aw_hs = m_axi.awvalid & m_axi.awready;
  assign w_hs  = m_axi.wvalid & m_axi.wready;
  assign b_hs  = m_axi.bvalid & m_axi.bready;

  always_comb begin
    wr_state_d = wr_state_q;
    wr_owner_d = wr_owner_q;
    aw_done_d  = aw_done_q;
    unique case (wr_state_q)
      W_IDLE: begin
        if (aw_req != 2'b00) begin
          wr_state_d = W_DATA;
          wr_owner_d = (aw_gnt == 2'b10) ? SRC_D : SRC_I;
          aw_done_d  = 1'b0;
        end
      end
      W_DATA: begin
        if (aw_hs) begin
          aw_done_d = 1'b1;
        end
        if (w_hs && own_wlast) begin
          wr_state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (b_hs) begin
          wr_state_d = W_IDLE;
        end
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_state_q <= W_IDLE;
      wr_owner_q <= SRC_I;
      aw_done_q  <= 1'b0;
    end else begin
      wr_state_q <= wr_state_d;
      wr_owner_q <= wr_owner_d;
      aw_done_q  <= aw_done_d;
    end
  end

endmodule

// File: tb/tb_intirvx_axi_arbiter.sv
// Directed self-checking bench for intirvx_axi_arbiter.
module tb_intirvx_axi_arbiter;
  import intirvx_axi_arbiter_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  axi5 i_if ();
  axi5 d_if ();
  axi5 m_if ();

  intirvx_axi_arbiter #(
    .MAX_RD_OUT (4),
    .CNT_W      (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .i_axi (i_if),
    .d_axi (d_if),
    .m_axi (m_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic init_inputs;
    i_if.awid = '0; i_if.awaddr = '0; i_if.awlen = '0; i_if.awsize = 3'd2; i_if.awburst = 2'd1;
    i_if.awvalid = 0; i_if.wdata = '0; i_if.wstrb = '1; i_if.wlast = 0; i_if.wvalid = 0;
    i_if.bready = 1; i_if.arid = '0; i_if.araddr = '0; i_if.arlen = '0; i_if.arsize = 3'd2;
    i_if.arburst = 2'd1; i_if.arvalid = 0; i_if.rready = 1;
    d_if.awid = 4'd1; d_if.awaddr = '0; d_if.awlen = '0; d_if.awsize = 3'd2; d_if.awburst = 2'd1;
    d_if.awvalid = 0; d_if.wdata = '0; d_if.wstrb = '1; d_if.wlast = 0; d_if.wvalid = 0;
    d_if.bready = 1; d_if.arid = 4'd1; d_if.araddr = '0; d_if.arlen = '0; d_if.arsize = 3'd2;
    d_if.arburst = 2'd1; d_if.arvalid = 0; d_if.rready = 1;
    m_if.awready = 1; m_if.wready = 1; m_if.bid = '0; m_if.bresp = '0; m_if.bvalid = 0;
    m_if.arready = 1; m_if.rid = '0; m_if.rdata = '0; m_if.rresp = '0; m_if.rlast = 0;
    m_if.rvalid = 0;
  endtask

  task automatic test_reset;
    logic [9:0] vr;
    rst_n = 1'b0;
    init_inputs();
    #3;
    vr = {m_if.arvalid, m_if.awvalid, m_if.wvalid, m_if.rready, m_if.bready,
          i_if.arready, i_if.awready, i_if.wready, i_if.rvalid, i_if.bvalid};
    checks++;
    if (vr !== 10'b0) begin
      failures++; $display("FAIL reset_handshakes: got %b want 0000000000", vr);
    end
    checks++;
    if (dut.rd_cnt_q !== 4'd0 || dut.rd_state_q !== R_IDLE || dut.wr_state_q !== W_IDLE) begin
      failures++;
      $display("FAIL reset_state: cnt=%0d rd=%0d wr=%0d want 0 0 0",
               dut.rd_cnt_q, dut.rd_state_q, dut.wr_state_q);
    end
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_single_read;
    i_if.arid = 4'd2; i_if.araddr = 32'h0000_1000; i_if.arlen = 8'd3; i_if.arvalid = 1;
    #1;
    checks++;
    if (m_if.arvalid !== 1'b0) begin
      failures++; $display("FAIL single_ar_latency: arvalid=%b want 0", m_if.arvalid);
    end
    cyc();
    checks++;
    if (m_if.arvalid !== 1'b1 || m_if.araddr !== 32'h0000_1000 || i_if.arready !== 1'b1) begin
      failures++;
      $display("FAIL single_ar_fwd: arvalid=%b addr=%h arready=%b want 1 00001000 1",
               m_if.arvalid, m_if.araddr, i_if.arready);
    end
    cyc();
    i_if.arvalid = 0;
    #1;
    checks++;
    if (dut.rd_cnt_q !== 4'd1) begin
      failures++; $display("FAIL single_cnt_inc: cnt=%0d want 1", dut.rd_cnt_q);
    end
    for (int k = 0; k < 4; k++) begin
      m_if.rvalid = 1; m_if.rid = 4'd2; m_if.rdata = 32'hB000 + k; m_if.rlast = (k == 3);
      #1;
      checks++;
      if (i_if.rvalid !== 1'b1 || i_if.rdata !== 32'hB000 + k || d_if.rvalid !== 1'b0) begin
        failures++;
        $display("FAIL single_r_beat%0d: i_rvalid=%b data=%h d_rvalid=%b want 1 %h 0",
                 k, i_if.rvalid, i_if.rdata, d_if.rvalid, 32'hB000 + k);
      end
      cyc();
    end
    m_if.rvalid = 0; m_if.rlast = 0;
    #1;
    checks++;
    if (dut.rd_cnt_q !== 4'd0 || dut.rd_state_q !== R_IDLE) begin
      failures++;
      $display("FAIL single_release: cnt=%0d state=%0d want 0 0", dut.rd_cnt_q, dut.rd_state_q);
    end
  endtask

  task automatic test_simul_read;
    i_if.arvalid = 1; i_if.araddr = 32'h100; i_if.arlen = 0;
    d_if.arvalid = 1; d_if.araddr = 32'h200; d_if.arlen = 0;
    cyc();
    checks++;
    if (m_if.araddr !== 32'h200 || i_if.arready !== 1'b0 || d_if.arready !== 1'b1) begin
      failures++;
      $display("FAIL simul_first: addr=%h i_ardy=%b d_ardy=%b want 00000200 0 1",
               m_if.araddr, i_if.arready, d_if.arready);
    end
    cyc();
    d_if.arvalid = 0;
    m_if.rvalid = 1; m_if.rlast = 1; m_if.rdata = 32'hD0;
    #1;
    checks++;
    if (d_if.rvalid !== 1'b1 || i_if.rvalid !== 1'b0 || i_if.arready !== 1'b0) begin
      failures++;
      $display("FAIL simul_d_resp: d_rvalid=%b i_rvalid=%b i_ardy=%b want 1 0 0",
               d_if.rvalid, i_if.rvalid, i_if.arready);
    end
    cyc();
    m_if.rvalid = 0; m_if.rlast = 0;
    #1;
    checks++;
    if (dut.rd_state_q !== R_IDLE || m_if.arvalid !== 1'b0) begin
      failures++;
      $display("FAIL simul_gap: state=%0d arvalid=%b want 0 0", dut.rd_state_q, m_if.arvalid);
    end
    cyc();
    checks++;
    if (m_if.arvalid !== 1'b1 || m_if.araddr !== 32'h100 || i_if.arready !== 1'b1) begin
      failures++;
      $display("FAIL simul_second: arvalid=%b addr=%h i_ardy=%b want 1 00000100 1",
               m_if.arvalid, m_if.araddr, i_if.arready);
    end
    cyc();
    i_if.arvalid = 0;
    m_if.rvalid = 1; m_if.rlast = 1;
    #1;
    checks++;
    if (i_if.rvalid !== 1'b1 || d_if.rvalid !== 1'b0) begin
      failures++;
      $display("FAIL simul_i_resp: i_rvalid=%b d_rvalid=%b want 1 0", i_if.rvalid, d_if.rvalid);
    end
    cyc();
    m_if.rvalid = 0; m_if.rlast = 0;
  endtask

  task automatic test_outstanding;
    int hs;
    int maxcnt;
    hs = 0; maxcnt = 0;
    d_if.arvalid = 1; d_if.araddr = 32'h4000; d_if.arlen = 0;
    repeat (8) begin
      #1;
      if (m_if.arvalid && m_if.arready) hs++;
      if (int'(dut.rd_cnt_q) > maxcnt) maxcnt = int'(dut.rd_cnt_q);
      cyc();
    end
    #1;
    checks++;
    if (hs != 4 || dut.rd_cnt_q !== 4'd4 || d_if.arready !== 1'b0) begin
      failures++;
      $display("FAIL outst_limit: hs=%0d cnt=%0d d_ardy=%b want 4 4 0",
               hs, dut.rd_cnt_q, d_if.arready);
    end
    m_if.rvalid = 1; m_if.rlast = 1;
    #1;
    checks++;
    if (d_if.arready !== 1'b0) begin
      failures++; $display("FAIL outst_hold_on_rlast: d_ardy=%b want 0", d_if.arready);
    end
    cyc();
    m_if.rvalid = 0; m_if.rlast = 0;
    #1;
    checks++;
    if (d_if.arready !== 1'b1 || dut.rd_cnt_q !== 4'd3) begin
      failures++;
      $display("FAIL outst_fifth: d_ardy=%b cnt=%0d want 1 3", d_if.arready, dut.rd_cnt_q);
    end
    cyc();
    d_if.arvalid = 0;
    #1;
    if (int'(dut.rd_cnt_q) > maxcnt) maxcnt = int'(dut.rd_cnt_q);
    checks++;
    if (dut.rd_cnt_q !== 4'd4 || maxcnt > 4) begin
      failures++;
      $display("FAIL outst_refill: cnt=%0d max=%0d want 4 <=4", dut.rd_cnt_q, maxcnt);
    end
    repeat (4) begin
      m_if.rvalid = 1; m_if.rlast = 1;
      cyc();
    end
    m_if.rvalid = 0; m_if.rlast = 0;
    #1;
    checks++;
    if (dut.rd_cnt_q !== 4'd0 || dut.rd_state_q !== R_IDLE) begin
      failures++;
      $display("FAIL outst_drain: cnt=%0d state=%0d want 0 0", dut.rd_cnt_q, dut.rd_state_q);
    end
  endtask

  task automatic test_ar_rlast_same;
    d_if.arvalid = 1; d_if.araddr = 32'h6000;
    cyc(); cyc(); cyc();
    checks++;
    if (dut.rd_cnt_q !== 4'd2) begin
      failures++; $display("FAIL same_pre: cnt=%0d want 2", dut.rd_cnt_q);
    end
    m_if.rvalid = 1; m_if.rlast = 1;
    cyc();
    d_if.arvalid = 0; m_if.rvalid = 0; m_if.rlast = 0;
    #1;
    checks++;
    if (dut.rd_cnt_q !== 4'd2 || dut.rd_state_q !== R_OWN) begin
      failures++;
      $display("FAIL same_hold: cnt=%0d state=%0d want 2 1", dut.rd_cnt_q, dut.rd_state_q);
    end
    repeat (2) begin
      m_if.rvalid = 1; m_if.rlast = 1;
      cyc();
    end
    m_if.rvalid = 0; m_if.rlast = 0;
    #1;
    checks++;
    if (dut.rd_state_q !== R_IDLE) begin
      failures++; $display("FAIL same_drain: state=%0d want 0", dut.rd_state_q);
    end
  endtask

  task automatic test_write;
    d_if.wvalid = 1; d_if.wdata = 32'hA5A5_A5A5; d_if.wlast = 0;
    #1;
    checks++;
    if (m_if.wvalid !== 1'b0 || d_if.wready !== 1'b0) begin
      failures++;
      $display("FAIL wr_early_w: m_wvalid=%b d_wready=%b want 0 0", m_if.wvalid, d_if.wready);
    end
    cyc(); cyc();
    d_if.awvalid = 1; d_if.awaddr = 32'h3000; d_if.awlen = 8'd1;
    #1;
    checks++;
    if (m_if.awvalid !== 1'b0) begin
      failures++; $display("FAIL wr_aw_latency: awvalid=%b want 0", m_if.awvalid);
    end
    cyc();
    i_if.awvalid = 1; i_if.awaddr = 32'h5000; i_if.awlen = 0;
    #1;
    checks++;
    if (m_if.awvalid !== 1'b1 || m_if.awaddr !== 32'h3000 || m_if.wvalid !== 1'b1 ||
        m_if.wdata !== 32'hA5A5_A5A5 || d_if.wready !== 1'b1 || i_if.awready !== 1'b0) begin
      failures++;
      $display("FAIL wr_grant: awv=%b addr=%h wv=%b wdata=%h d_wrdy=%b i_awrdy=%b want 1 3000 1 a5a5a5a5 1 0",
               m_if.awvalid, m_if.awaddr, m_if.wvalid, m_if.wdata, d_if.wready, i_if.awready);
    end
    cyc();
    d_if.awvalid = 0; d_if.wdata = 32'h5A5A_5A5A; d_if.wlast = 1;
    #1;
    checks++;
    if (m_if.wvalid !== 1'b1 || m_if.wdata !== 32'h5A5A_5A5A || m_if.wlast !== 1'b1 ||
        m_if.awvalid !== 1'b0) begin
      failures++;
      $display("FAIL wr_beat2: wv=%b wdata=%h wlast=%b awv=%b want 1 5a5a5a5a 1 0",
               m_if.wvalid, m_if.wdata, m_if.wlast, m_if.awvalid);
    end
    cyc();
    d_if.wvalid = 0; d_if.wlast = 0;
    #1;
    checks++;
    if (dut.wr_state_q !== W_RESP || i_if.awready !== 1'b0 || m_if.awvalid !== 1'b0) begin
      failures++;
      $display("FAIL wr_resp_stall: state=%0d i_awrdy=%b awv=%b want 2 0 0",
               dut.wr_state_q, i_if.awready, m_if.awvalid);
    end
    cyc();
    m_if.bvalid = 1; m_if.bresp = 2'b00; m_if.bid = 4'd1;
    #1;
    checks++;
    if (d_if.bvalid !== 1'b1 || d_if.bresp !== 2'b00 || i_if.bvalid !== 1'b0 ||
        m_if.bready !== 1'b1) begin
      failures++;
      $display("FAIL wr_b_route: d_bv=%b bresp=%b i_bv=%b bready=%b want 1 00 0 1",
               d_if.bvalid, d_if.bresp, i_if.bvalid, m_if.bready);
    end
    cyc();
    m_if.bvalid = 0;
    #1;
    checks++;
    if (dut.wr_state_q !== W_IDLE || m_if.awvalid !== 1'b0) begin
      failures++;
      $display("FAIL wr_idle: state=%0d awv=%b want 0 0", dut.wr_state_q, m_if.awvalid);
    end
    cyc();
    i_if.wvalid = 1; i_if.wdata = 32'h0000_1234; i_if.wlast = 1;
    #1;
    checks++;
    if (m_if.awvalid !== 1'b1 || m_if.awaddr !== 32'h5000 || i_if.awready !== 1'b1 ||
        m_if.wvalid !== 1'b0) begin
      failures++;
      $display("FAIL wr_i_grant: awv=%b addr=%h i_awrdy=%b wv=%b want 1 5000 1 0",
               m_if.awvalid, m_if.awaddr, i_if.awready, m_if.wvalid);
    end
    cyc();
    i_if.awvalid = 0;
    #1;
    checks++;
    if (m_if.wvalid !== 1'b1 || m_if.wdata !== 32'h0000_1234 || i_if.wready !== 1'b1) begin
      failures++;
      $display("FAIL wr_i_data: wv=%b wdata=%h i_wrdy=%b want 1 1234 1",
               m_if.wvalid, m_if.wdata, i_if.wready);
    end
    cyc();
    i_if.wvalid = 0; i_if.wlast = 0; m_if.bvalid = 1;
    #1;
    checks++;
    if (i_if.bvalid !== 1'b1 || d_if.bvalid !== 1'b0) begin
      failures++;
      $display("FAIL wr_i_b: i_bv=%b d_bv=%b want 1 0", i_if.bvalid, d_if.bvalid);
    end
    cyc();
    m_if.bvalid = 0;
  endtask

  task automatic test_reset_mid_read;
    logic [4:0] v;
    i_if.arvalid = 1; i_if.araddr = 32'h2000; i_if.arlen = 8'd3;
    cyc(); cyc();
    i_if.arvalid = 0;
    repeat (2) begin
      m_if.rvalid = 1; m_if.rlast = 0;
      cyc();
    end
    m_if.rvalid = 1;
    #2;
    rst_n = 1'b0;
    #1;
    v = {m_if.rready, i_if.rvalid, m_if.arvalid, i_if.arready, m_if.bready};
    checks++;
    if (v !== 5'b0 || dut.rd_cnt_q !== 4'd0 || dut.rd_state_q !== R_IDLE ||
        dut.wr_state_q !== W_IDLE) begin
      failures++;
      $display("FAIL rst_mid: hs=%b cnt=%0d rd=%0d wr=%0d want 00000 0 0 0",
               v, dut.rd_cnt_q, dut.rd_state_q, dut.wr_state_q);
    end
    m_if.rvalid = 0;
    cyc();
    rst_n = 1'b1;
    cyc();
    i_if.arvalid = 1; i_if.araddr = 32'h2400; i_if.arlen = 0;
    cyc(); cyc();
    i_if.arvalid = 0;
    m_if.rvalid = 1; m_if.rlast = 1; m_if.rdata = 32'hCAFE;
    #1;
    checks++;
    if (i_if.rvalid !== 1'b1 || i_if.rdata !== 32'hCAFE || dut.rd_cnt_q !== 4'd1) begin
      failures++;
      $display("FAIL rst_fresh: i_rv=%b data=%h cnt=%0d want 1 cafe 1",
               i_if.rvalid, i_if.rdata, dut.rd_cnt_q);
    end
    cyc();
    m_if.rvalid = 0; m_if.rlast = 0;
    #1;
    checks++;
    if (dut.rd_state_q !== R_IDLE || dut.rd_cnt_q !== 4'd0) begin
      failures++;
      $display("FAIL rst_fresh_done: state=%0d cnt=%0d want 0 0", dut.rd_state_q, dut.rd_cnt_q);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_single_read();
    test_simul_read();
    test_outstanding();
    test_ar_rlast_same();
    test_write();
    test_reset_mid_read();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
